// File: rtl/team_07_button_event_ctrl_pkg.sv
// Shared types and constants for the team_07 button front-end.
package team_07_btn_pkg;

    localparam int NUM_BTN = 6;

    typedef logic [NUM_BTN-1:0] btn_t;

    localparam btn_t BTN_SELECT = 6'h01;
    localparam btn_t BTN_UP     = 6'h02;
    localparam btn_t BTN_RIGHT  = 6'h04;
    localparam btn_t BTN_DOWN   = 6'h08;
    localparam btn_t BTN_LEFT   = 6'h10;
    localparam btn_t BTN_BACK   = 6'h20;

    // Isolate the lowest set bit; index 0 (SELECT) has the highest priority.
    function automatic btn_t lowest_one(input btn_t v);
        return v & (~v + btn_t'(1));
    endfunction

endpackage

// File: rtl/team_07_button_event_ctrl_if.sv
// Event handshake between the button front-end (master) and the game core (slave).
interface team_07_button_event_ctrl_if;
    import team_07_btn_pkg::*;

    logic evt_valid;
    logic evt_ready;
    btn_t evt_btn;

    modport master (output evt_valid, output evt_btn, input evt_ready);
    modport slave  (input evt_valid, input evt_btn, output evt_ready);
endinterface

// File: rtl/team_07_button_event_ctrl_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and press pulse.
module team_07_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync_q;
            cnt_d   = '0;
            rise_d  = sync_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state; the press pulse is registered alongside the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/team_07_button_event_ctrl.sv
// Button front-end: per-button debounce, pending/priority arbiter and event FIFO to the core.
module team_07_button_event_ctrl
    import team_07_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  btn_t                        btn_raw,
    team_07_button_event_ctrl_if.master evt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output btn_t                        btn_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    btn_t          press;
    btn_t          pend_q, pend_d;
    btn_t          grant;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    btn_t          mem_q [FIFO_DEPTH];
    logic          full, valid, push, pop;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        team_07_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (btn_raw[i]),
            .level_o(btn_level[i]),
            .rise_o (press[i])
        );
    end

    // A full queue blocks the push even if the head is popped in the same cycle.
    assign full  = (level_q == FULL_LVL);
    assign valid = en & (level_q != '0);
    assign pop   = valid & evt.evt_ready;
    assign grant = lowest_one(pend_q);
    assign push  = en & (pend_q != '0) & ~full;

    // Pending/overflow update and FIFO pointer arithmetic; en low flushes everything.
    always_comb begin
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (!en) begin
            pend_d   = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // A repeat press on a still-pending button is lost only when nothing can drain it.
            if (full && ((press & pend_q) != '0)) begin
                ovf_d = 1'b1;
            end
            pend_d = (push ? (pend_q & ~grant) : pend_q) | press;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Event storage; contents are don't-care until pointed at by a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= grant;
        end
    end

    assign evt.evt_valid = valid;
    assign evt.evt_btn   = valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level    = level_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_team_07_button_event_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a queue-based model.
module tb_team_07_button_event_ctrl;
    import team_07_btn_pkg::*;

    localparam int DB    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    btn_t       btn_raw;
    logic [2:0] fifo_level;
    logic       overflow;
    btn_t       btn_level;

    team_07_button_event_ctrl_if bus();

    team_07_button_event_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .btn_raw   (btn_raw),
        .evt       (bus),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_on = 0;

    // model state
    btn_t raw_d[$];
    btn_t syn_hist[$];
    btn_t m_level, m_press, m_pend;
    bit   m_ovf;
    btn_t m_q[$];
    btn_t seen[$];

    btn_t exp4[5] = '{BTN_SELECT, BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Spec-level reference: pin level follows a 2-sample delay; a level flips once the
    // last DB synced samples all disagree with it; events drain through a queue.
    task automatic model_step();
        btn_t syn, flip, grant;
        bit   full, mv, pop, all_diff;
        if (rst) begin
            raw_d = '{6'h00, 6'h00};
            syn_hist.delete();
            m_level = '0;
            m_press = '0;
            m_pend  = '0;
            m_ovf   = 0;
            m_q.delete();
            return;
        end
        mv   = en && (m_q.size() > 0);
        pop  = mv && bus.evt_ready;
        full = (m_q.size() == DEPTH);
        if (!en) begin
            m_q.delete();
            m_pend = '0;
            m_ovf  = 0;
        end else begin
            if (full && ((m_press & m_pend) != 0)) m_ovf = 1;
            grant = '0;
            if (!full) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (m_pend[i]) begin
                        grant[i] = 1'b1;
                        break;
                    end
                end
            end
            if (pop) void'(m_q.pop_front());
            if (grant != 0) m_q.push_back(grant);
            m_pend = (m_pend & ~grant) | m_press;
        end
        syn = raw_d.pop_front();
        raw_d.push_back(btn_raw);
        syn_hist.push_back(syn);
        if (syn_hist.size() > DB) void'(syn_hist.pop_front());
        flip = '0;
        if (syn_hist.size() == DB) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                all_diff = 1;
                foreach (syn_hist[k]) if (syn_hist[k][i] == m_level[i]) all_diff = 0;
                flip[i] = all_diff;
            end
        end
        m_press = flip & ~m_level;
        m_level = m_level ^ flip;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, mid-cycle.
    initial forever begin : cmp
        bit   mv;
        btn_t mb;
        @(negedge clk);
        if (chk_on) begin
            mv = en && (m_q.size() > 0);
            mb = mv ? m_q[0] : '0;
            chk("evt_valid",  32'(bus.evt_valid), 32'(mv));
            chk("evt_btn",    32'(bus.evt_btn),   32'(mb));
            chk("fifo_level", 32'(fifo_level),    32'(m_q.size()));
            chk("overflow",   32'(overflow),      32'(m_ovf));
            chk("btn_level",  32'(btn_level),     32'(m_level));
            if (bus.evt_valid && bus.evt_ready) seen.push_back(bus.evt_btn);
        end
    end

    initial begin
        int base;
        int rdy_pct;
        rst = 1'b1;
        en = 1'b1;
        btn_raw = '0;
        bus.evt_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_on = 1;
        chk("reset_valid", 32'(bus.evt_valid), 32'(0));
        chk("reset_level", 32'(fifo_level), 32'(0));
        chk("reset_btnlvl", 32'(btn_level), 32'(0));

        // 1: single SELECT press
        base = seen.size();
        btn_raw = BTN_SELECT;
        tick(17);
        chk("t1_lvl_before", 32'(btn_level), 32'(0));
        tick(1);
        chk("t1_lvl_rise", 32'(btn_level), 32'(BTN_SELECT));
        tick(1);
        chk("t1_valid_pend", 32'(bus.evt_valid), 32'(0));
        tick(1);
        chk("t1_valid", 32'(bus.evt_valid), 32'(1));
        chk("t1_btn", 32'(bus.evt_btn), 32'(BTN_SELECT));
        tick(1);
        chk("t1_valid_gone", 32'(bus.evt_valid), 32'(0));
        tick(79);
        btn_raw = '0;
        tick(30);
        chk("t1_count", 32'(seen.size() - base), 32'(1));

        // 2: bouncing UP, then held
        base = seen.size();
        for (int k = 0; k < 12; k++) begin
            btn_raw = (k % 2 == 0) ? BTN_UP : 6'h00;
            tick(5);
        end
        btn_raw = BTN_UP;
        tick(19);
        chk("t2_valid_early", 32'(bus.evt_valid), 32'(0));
        tick(1);
        chk("t2_valid", 32'(bus.evt_valid), 32'(1));
        chk("t2_btn", 32'(bus.evt_btn), 32'(BTN_UP));
        tick(20);
        btn_raw = '0;
        tick(30);
        chk("t2_count", 32'(seen.size() - base), 32'(1));

        // 3: RIGHT and LEFT together
        base = seen.size();
        btn_raw = BTN_RIGHT | BTN_LEFT;
        tick(20);
        chk("t3_first", 32'(bus.evt_btn), 32'(BTN_RIGHT));
        tick(1);
        chk("t3_second", 32'(bus.evt_btn), 32'(BTN_LEFT));
        tick(1);
        chk("t3_valid_gone", 32'(bus.evt_valid), 32'(0));
        btn_raw = '0;
        tick(30);
        chk("t3_count", 32'(seen.size() - base), 32'(2));

        // 4: fill, overflow, drain
        bus.evt_ready = 1'b0;
        btn_raw = 6'h0F;
        tick(25);
        chk("t4_full", 32'(fifo_level), 32'(4));
        chk("t4_head", 32'(bus.evt_btn), 32'(BTN_SELECT));
        btn_raw = 6'h1F;
        tick(22);
        chk("t4_still_full", 32'(fifo_level), 32'(4));
        chk("t4_no_ovf", 32'(overflow), 32'(0));
        btn_raw = 6'h0F;
        tick(20);
        btn_raw = 6'h1F;
        tick(20);
        chk("t4_ovf", 32'(overflow), 32'(1));
        base = seen.size();
        bus.evt_ready = 1'b1;
        tick(1);
        bus.evt_ready = 1'b0;
        chk("t4_after_pop", 32'(fifo_level), 32'(3));
        tick(1);
        chk("t4_left_in", 32'(fifo_level), 32'(4));
        bus.evt_ready = 1'b1;
        tick(10);
        chk("t4_count", 32'(seen.size() - base), 32'(5));
        for (int k = 0; k < 5; k++)
            if (base + k < seen.size()) chk("t4_order", 32'(seen[base+k]), 32'(exp4[k]));
        chk("t4_ovf_sticky", 32'(overflow), 32'(1));
        btn_raw = '0;
        tick(25);

        // 5: reset mid-stream
        bus.evt_ready = 1'b0;
        btn_raw = 6'h07;
        tick(25);
        chk("t5_level3", 32'(fifo_level), 32'(3));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        btn_raw = '0;
        chk("t5_valid", 32'(bus.evt_valid), 32'(0));
        chk("t5_level", 32'(fifo_level), 32'(0));
        chk("t5_ovf", 32'(overflow), 32'(0));
        chk("t5_btnlvl", 32'(btn_level), 32'(0));
        bus.evt_ready = 1'b1;
        tick(40);

        // 6: enable low flushes; held BACK yields nothing until re-pressed
        bus.evt_ready = 1'b0;
        btn_raw = 6'h03;
        tick(25);
        chk("t6_level2", 32'(fifo_level), 32'(2));
        btn_raw = 6'h23;
        en = 1'b0;
        #1;
        chk("t6_valid_off", 32'(bus.evt_valid), 32'(0));
        tick(25);
        chk("t6_flushed", 32'(fifo_level), 32'(0));
        chk("t6_back_lvl", 32'(btn_level), 32'(6'h23));
        en = 1'b1;
        tick(10);
        chk("t6_no_evt", 32'(bus.evt_valid), 32'(0));
        btn_raw = 6'h03;
        tick(20);
        btn_raw = 6'h23;
        tick(20);
        chk("t6_back_valid", 32'(bus.evt_valid), 32'(1));
        chk("t6_back_btn", 32'(bus.evt_btn), 32'(BTN_BACK));
        bus.evt_ready = 1'b1;
        tick(5);
        btn_raw = '0;
        tick(30);

        // random phase
        for (int r = 0; r < 160; r++) begin
            int n;
            if ($urandom_range(0, 2) == 0)
                btn_raw = btn_t'($urandom_range(0, 63));
            else
                btn_raw = btn_raw ^ btn_t'(1 << $urandom_range(0, 5));
            en  = ($urandom_range(0, 14) != 0);
            rst = ($urandom_range(0, 39) == 0);
            rdy_pct = $urandom_range(0, 100);
            n = $urandom_range(1, 35);
            for (int c = 0; c < n; c++) begin
                bus.evt_ready = ($urandom_range(0, 99) < rdy_pct);
                tick(1);
                rst = 1'b0;
            end
        end
        en = 1'b1;
        bus.evt_ready = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
